work_dispatch: RTL and testbench

Host-side counterpart of the miner's serial link. It serialises a 352-bit work block (32-byte midstate plus 12 bytes of remaining block data) into 44 bytes, sent MSB-first through a byte-level UART transmitter. It also reassembles 4-byte nonce results arriving from a UART receiver into 32-bit words. It sits between a work source (or a test harness) and a pair of UART byte engines, driving a miner board.

---
 rtl/work_dispatch.sv | 173 +++++++++++++++++
 tb/tb_work_dispatch.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/work_dispatch.sv
// Host-side work dispatcher: serialises 352-bit work blocks into 44 UART bytes and
// reassembles 4-byte nonce results. Optional RX idle timeout: WORK_DISPATCH_TIMEOUT_EN.
module work_dispatch #(
  parameter int unsigned CLK_RATE   = 100000000,
  parameter int unsigned RX_TIMEOUT = CLK_RATE / 1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [351:0] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output logic         block_sent,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic [7:0]   in_byte,
  input  logic         in_new,
  output logic [31:0]  result_out,
  output logic         result_valid,
  output logic         rx_drop
);

  localparam int unsigned BLK_W  = 352;
  localparam int unsigned NBYTES = 44;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned HOLD_W = 24;

  typedef enum logic [1:0] {IDLE, SEND, DONE} tx_state_e;

  tx_state_e        state_q, state_d;
  logic [BLK_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_valid_q, out_valid_d;
  logic             block_sent_q, block_sent_d;

  logic [1:0]        rx_cnt_q, rx_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [31:0]       result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              rx_drop_q, rx_drop_d;

  assign block_ready  = (state_q == IDLE);
  assign block_sent   = block_sent_q;
  assign out_byte     = out_byte_q;
  assign out_valid    = out_valid_q;
  assign result_out   = result_q;
  assign result_valid = result_valid_q;
  assign rx_drop      = rx_drop_q;

  // TX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      tx_cnt_q     <= '0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      block_sent_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      tx_cnt_q     <= tx_cnt_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      block_sent_q <= block_sent_d;
    end
  end

  // TX next state; out_byte/out_valid are computed one step ahead so they are registered
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    tx_cnt_d     = tx_cnt_q;
    out_byte_d   = out_byte_q;
    out_valid_d  = out_valid_q;
    block_sent_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (block_valid) begin
          shift_d     = block_in;
          tx_cnt_d    = '0;
          out_valid_d = 1'b1;
          out_byte_d  = block_in[BLK_W-1 -: 8];
          state_d     = SEND;
        end
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          shift_d  = shift_q << 8;
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          if (tx_cnt_q == CNT_W'(NBYTES - 1)) begin
            out_valid_d = 1'b0;
            out_byte_d  = '0;
            state_d     = DONE;
          end else begin
            out_byte_d = shift_q[BLK_W-9 -: 8];
          end
        end
      end
      DONE: begin
        block_sent_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WORK_DISPATCH_TIMEOUT_EN
  localparam logic [31:0] IDLE_LIMIT = 32'(RX_TIMEOUT - 1);
  logic [31:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(RX_TIMEOUT);
`endif

  // RX assembler registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_cnt_q       <= '0;
      hold_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      rx_drop_q      <= 1'b0;
`ifdef WORK_DISPATCH_TIMEOUT_EN
      idle_q         <= '0;
`endif
    end else begin
      rx_cnt_q       <= rx_cnt_d;
      hold_q         <= hold_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      rx_drop_q      <= rx_drop_d;
`ifdef WORK_DISPATCH_TIMEOUT_EN
      idle_q         <= idle_d;
`endif
    end
  end

  // RX next state; an arriving byte always wins over a coincident timeout
  always_comb begin
    rx_cnt_d       = rx_cnt_q;
    hold_d         = hold_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    rx_drop_d      = 1'b0;
`ifdef WORK_DISPATCH_TIMEOUT_EN
    idle_d         = '0;
`endif
    if (in_new) begin
      rx_cnt_d = rx_cnt_q + 2'd1;
      if (rx_cnt_q == 2'd3) begin
        result_d       = {hold_q, in_byte};
        result_valid_d = 1'b1;
        hold_d         = '0;
      end else begin
        hold_d = {hold_q[HOLD_W-9:0], in_byte};
      end
    end
`ifdef WORK_DISPATCH_TIMEOUT_EN
    else if (rx_cnt_q != 2'd0) begin
      if (idle_q == IDLE_LIMIT) begin
        rx_cnt_d  = '0;
        hold_d    = '0;
        rx_drop_d = 1'b1;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_work_dispatch.sv
// Scoreboard bench for work_dispatch: stimulus pushes expected TX bytes and results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_work_dispatch;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [351:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic         block_sent;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   in_byte;
  logic         in_new;
  logic [31:0]  result_out;
  logic         result_valid;
  logic         rx_drop;

  work_dispatch #(.CLK_RATE(100000), .RX_TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .block_in(block_in), .block_valid(block_valid), .block_ready(block_ready),
    .block_sent(block_sent), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .in_byte(in_byte), .in_new(in_new),
    .result_out(result_out), .result_valid(result_valid), .rx_drop(rx_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] res_q[$];
  int xfer_cnt = 0;
  int sent_cnt = 0;
  int sent_cyc = 0;
  int drop_cnt = 0;
  int acc_cyc  = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_byte", 32'(out_byte), 32'(prev_byte));
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      if (out_valid) check("ready_low_busy", 32'(block_ready), 32'd0);
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (tx_q.size() == 0) check("tx_unexpected", 32'(out_byte), 32'hFFFF_FFFF);
        else check("tx_byte", 32'(out_byte), 32'(tx_q.pop_front()));
      end
      if (block_sent) begin
        sent_cnt++;
        sent_cyc = cyc;
      end
      if (result_valid) begin
        if (res_q.size() == 0) check("res_unexpected", result_out, 32'hFFFF_FFFF);
        else check("result", result_out, res_q.pop_front());
      end
      if (rx_drop) drop_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [351:0] make_block(input int mul, input int add);
    logic [351:0] b;
    for (int i = 0; i < 44; i++) b[351-8*i -: 8] = 8'(i * mul + add);
    return b;
  endfunction

  task automatic send_block(input logic [351:0] b);
    int k;
    for (k = 0; k < 200 && !block_ready; k++) step();
    check("ready_wait", 32'(block_ready), 32'd1);
    block_in    = b;
    block_valid = 1'b1;
    for (int i = 0; i < 44; i++) tx_q.push_back(b[351-8*i -: 8]);
    step();
    block_valid = 1'b0;
    acc_cyc     = cyc;
    check("first_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic wait_sent(input int n, input bit bp);
    int k;
    for (k = 0; k < 3000 && sent_cnt < n; k++) begin
      if (bp) out_ready = ($urandom_range(0, 9) >= 7);
      step();
    end
    out_ready = 1'b1;
    check("sent_count", 32'(sent_cnt), 32'(n));
  endtask

  task automatic rx_byte(input logic [7:0] b);
    in_byte = b;
    in_new  = 1'b1;
    step();
    in_new  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int k;
    rst_n = 1'b0; block_in = '0; block_valid = 1'b0; out_ready = 1'b1;
    in_byte = '0; in_new = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_block_sent", 32'(block_sent), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_rx_drop", 32'(rx_drop), 32'd0);
    check("rst_result_out", result_out, 32'd0);
    check("rst_block_ready", 32'(block_ready), 32'd1);

    // block of bytes 0x00..0x2B, no backpressure
    x0 = xfer_cnt;
    send_block(make_block(1, 0));
    wait_sent(1, 1'b0);
    check("xfers_blk1", 32'(xfer_cnt - x0), 32'd44);
    check("sent_latency", 32'(sent_cyc - acc_cyc), 32'd45);
    check("tx_q_empty1", 32'(tx_q.size()), 32'd0);
    step();
    check("sent_one_pulse", 32'(block_sent), 32'd0);

    // identical block under heavy backpressure
    x0 = xfer_cnt;
    send_block(make_block(1, 0));
    wait_sent(2, 1'b1);
    check("xfers_bp", 32'(xfer_cnt - x0), 32'd44);
    check("tx_q_empty2", 32'(tx_q.size()), 32'd0);

    // result assembly, bytes 10 cycles apart
    res_q.push_back(32'hDEADBEEF);
    rx_byte(8'hDE); repeat (9) step();
    rx_byte(8'hAD); repeat (9) step();
    rx_byte(8'hBE); repeat (9) step();
    check("res_early", 32'(result_valid), 32'd0);
    rx_byte(8'hEF);
    check("res_valid_pulse", 32'(result_valid), 32'd1);
    check("res_value", result_out, 32'hDEADBEEF);
    step();
    check("res_valid_low", 32'(result_valid), 32'd0);
    repeat (5) step();
    check("res_hold", result_out, 32'hDEADBEEF);

    // partial frame followed by a long gap
    rx_byte(8'h11);
    rx_byte(8'h22);
`ifdef WORK_DISPATCH_TIMEOUT_EN
    for (k = 1; k < 200; k++) begin
      step();
      if (rx_drop) break;
    end
    check("drop_cycle", 32'(k), 32'd100);
    repeat (150 - k) step();
    res_q.push_back(32'hA1A2A3A4);
    rx_byte(8'hA1); rx_byte(8'hA2); rx_byte(8'hA3); rx_byte(8'hA4);
    step();
    check("after_drop", result_out, 32'hA1A2A3A4);
    check("drop_count", 32'(drop_cnt), 32'd1);
`else
    repeat (150) step();
    check("no_drop", 32'(drop_cnt), 32'd0);
    res_q.push_back(32'h1122A1A2);
    rx_byte(8'hA1); rx_byte(8'hA2);
    step();
    check("no_timeout_frame", result_out, 32'h1122A1A2);
    res_q.push_back(32'hA3A4B1B2);
    rx_byte(8'hA3); rx_byte(8'hA4); rx_byte(8'hB1); rx_byte(8'hB2);
    step();
    check("next_frame", result_out, 32'hA3A4B1B2);
`endif

    // reset in the middle of a block
    x0 = xfer_cnt;
    send_block(make_block(3, 5));
    for (k = 0; k < 200 && (xfer_cnt - x0) < 20; k++) step();
    check("mid_xfers", 32'(xfer_cnt - x0), 32'd20);
    rst_n = 1'b0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tx_q.delete();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_block_ready", 32'(block_ready), 32'd1);
    check("midrst_result", result_out, 32'd0);
    step();
    check("midrst_no_sent", 32'(sent_cnt), 32'd2);
    x0 = xfer_cnt;
    send_block(make_block(5, 1));
    wait_sent(3, 1'b0);
    check("xfers_restart", 32'(xfer_cnt - x0), 32'd44);

    // TX with interleaved RX traffic
    x0 = xfer_cnt;
    send_block(make_block(7, 3));
    res_q.push_back(32'hCAFEF00D);
    fork
      wait_sent(4, 1'b0);
      begin
        repeat (4) step(); rx_byte(8'hCA);
        rx_byte(8'hFE);
        repeat (10) step(); rx_byte(8'hF0);
        repeat (12) step(); rx_byte(8'h0D);
      end
    join
    step();
    check("conc_xfers", 32'(xfer_cnt - x0), 32'd44);
    check("conc_result", result_out, 32'hCAFEF00D);
    check("tx_q_final", 32'(tx_q.size()), 32'd0);
    check("res_q_final", 32'(res_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
